// File: rtl/priority_state_arbiter.sv
// rtl/priority_state_arbiter.sv - two-state request arbiter with fixed/round-robin priority and hold timeout
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   req           level-sensitive request lines, one per requester
//   rr_mode       0 = fixed priority (highest index wins), 1 = round-robin
//   owner_release current owner ends its grant
//   grant         registered one-hot grant
//   next_state    registered index of the current or most recent winner
//   valid         high while a grant is held
//   timeout       one-cycle pulse in the final grant cycle when the hold limit revokes it
module priority_state_arbiter #(
    parameter int N_REQ    = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             rr_mode,
    input  logic             owner_release,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] next_state,
    output logic             valid,
    output logic             timeout
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;
    localparam logic [N_REQ-1:0]  ONE_HOT0   = N_REQ'(1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  idx_d;
    logic [N_REQ-1:0]  grant_d;
    logic              valid_d;

    logic [IDX_W-1:0]  winner;
    logic              found;
    int                rr_idx;
    logic [IDX_W-1:0]  cand;
    logic              owner_req;
    logic              hold_hit;
    logic              exit_grant;

    // Winner selection. Fixed mode: the last set bit seen in an ascending
    // scan is the highest index. Round-robin: scan last-1, last-2, ...
    // wrapping, so the previous winner is visited last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        rr_idx = 0;
        cand   = '0;
        if (!rr_mode) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[IDX_W'(i)]) begin
                    winner = IDX_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= N_REQ; k++) begin
                rr_idx = int'(last_q) + N_REQ - k;
                if (rr_idx >= N_REQ) begin
                    rr_idx = rr_idx - N_REQ;
                end
                cand = IDX_W'(rr_idx);
                if (!found && req[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
    end

    assign owner_req  = req[next_state];
    assign hold_hit   = (MAX_HOLD != 0) && (hold_q == HOLD_LIMIT);
    assign exit_grant = owner_release || !owner_req || hold_hit;

    // Only the hold limit may raise timeout; a coincident release or
    // withdrawal takes precedence and suppresses the pulse.
    assign timeout = (state_q == GRANT) && hold_hit && !owner_release && owner_req;

    always_comb begin
        state_d = state_q;
        grant_d = grant;
        idx_d   = next_state;
        valid_d = valid;
        hold_d  = hold_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                hold_d  = '0;
                if (|req) begin
                    state_d = GRANT;
                    grant_d = ONE_HOT0 << winner;
                    idx_d   = winner;
                    valid_d = 1'b1;
                    hold_d  = HOLD_W'(1);
                    last_d  = winner;
                end
            end
            GRANT: begin
                if (exit_grant) begin
                    state_d = IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant      <= '0;
            next_state <= '0;
            valid      <= 1'b0;
            hold_q     <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant      <= grant_d;
            next_state <= idx_d;
            valid      <= valid_d;
            hold_q     <= hold_d;
            last_q     <= last_d;
        end
    end

endmodule

// File: doc/priority_state_arbiter.md
PRIORITY_STATE_ARBITER -- requirements
Module: priority_state_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, giving the number of request lines (2..32).
REQ-002 SHALL have parameter IDX_W, default 2, giving the encoded index width; the integrator sets it to ceil(log2(N_REQ)).
REQ-003 SHALL have parameter MAX_HOLD, default 15, giving the maximum number of GRANT cycles; 0 disables the timeout.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port req, input, N_REQ bits: request lines, level-sensitive.
REQ-007 SHALL have port rr_mode, input, 1 bit: 0 selects fixed priority, 1 selects round-robin.
REQ-008 SHALL have port release, input, 1 bit: the current owner ends its grant.
REQ-009 SHALL have port grant, output, N_REQ bits: one-hot grant, registered.
REQ-010 SHALL have port next_state, output, IDX_W bits: encoded index of the current or last winner, registered.
REQ-011 SHALL have port valid, output, 1 bit: high while in GRANT.
REQ-012 SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-014 In IDLE with req==0, SHALL stay in IDLE with grant=0 and valid=0, and next_state holding its last value.
REQ-015 In IDLE with req!=0, SHALL arbitrate and, at the next edge, enter GRANT with grant=onehot(winner), next_state=winner, valid=1; latency from req to grant is 1 cycle.
REQ-016 Fixed mode (rr_mode=0) SHALL give priority to the highest index: req[N_REQ-1] wins, then descending.
REQ-017 Round-robin mode (rr_mode=1) SHALL search from index last_winner-1 downward, wrap from 0 to N_REQ-1, and give last_winner lowest priority.
REQ-018 SHALL update last_winner on every GRANT entry, in both modes.
REQ-019 SHALL sample rr_mode only in the IDLE arbitration cycle; changes during GRANT have no effect on the current grant.
REQ-020 In GRANT, SHALL hold grant, next_state and valid stable, independent of other req bits.
REQ-021 SHALL leave GRANT for IDLE at the next edge when any of these holds: release=1; req[next_state]=0; or the hold count equals MAX_HOLD with MAX_HOLD!=0.
REQ-022 SHALL keep a hold counter that is 1 in the first GRANT cycle, increments each GRANT cycle, saturates, and clears in IDLE; its width is ceil(log2(MAX_HOLD+1)).
REQ-023 SHALL assert timeout for exactly the final GRANT cycle when the exit cause is the hold limit only.
REQ-024 When release=1 or the owner's req drops in the same cycle as the hold limit, SHALL exit without asserting timeout.
REQ-025 SHALL spend at least one IDLE cycle between consecutive grants; back-to-back grants are not allowed.
REQ-026 SHALL assert grant with at most one bit set at all times, and valid==|grant.

Reset
REQ-027 While rst=1, SHALL force, asynchronously and without waiting for clk: state=IDLE, grant=0, next_state=0, valid=0, timeout=0, hold counter=0, last_winner=0.
REQ-028 Reset during GRANT SHALL abort the grant immediately, with no timeout pulse.
REQ-029 After rst deasserts, SHALL make the first round-robin search start at N_REQ-1, identical to fixed priority.

Verification (N_REQ=4, IDX_W=2, MAX_HOLD=15)
REQ-030 SHALL verify fixed priority: rr_mode=0, req=4'b0110 from IDLE -> next cycle grant=4'b0100, next_state=2, valid=1.
REQ-031 SHALL verify round-robin rotation: rr_mode=1, req=4'b1111 held, release pulsed in each GRANT -> successive winners 3,2,1,0,3, each separated by one IDLE cycle.
REQ-032 SHALL verify timeout: req=4'b0001 held, release=0 -> grant=4'b0001 for 15 cycles, timeout high in cycle 15, then 1 IDLE cycle, then re-grant to index 0.
REQ-033 SHALL verify release winning over timeout: release=1 in hold cycle 15 -> IDLE next cycle, timeout stays 0.
REQ-034 SHALL verify owner withdrawal: grant=4'b1000, then req[3] drops -> IDLE next edge, valid=0, next_state stays 3.
REQ-035 SHALL verify asynchronous reset: rst pulsed mid-GRANT between clock edges -> grant=0, valid=0, next_state=0 immediately; with req=4'b1111 and rr_mode=1 after release of rst -> first winner 3.
